// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB / CBC-encrypt / CTR block-mode controller wrapped around
// one iterative AES-128 encrypt core (AES_ENC, defined below).
// Input and output block FIFOs with valid/ready handshakes; one block in flight.
// Optional build macro AES_CTR_MODE_EN: when defined, CTR mode (mode=10) and
// its counter register exist; when undefined, mode=10 is rejected like 11.

// Iterative AES-128 encryptor: one round per clock, 11-cycle Drdy->Dvld.
// Round keys are rolled forward on the fly from the stored cipher key.
module AES_ENC (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         EN,
  input  logic         Krdy,
  input  logic         Drdy,
  input  logic [127:0] Key,
  input  logic [127:0] Din,
  output logic [127:0] Dout,
  output logic         BSY,
  output logic         Dvld
);
  logic [127:0] key_q, rk_q, st_q, dout_q;
  logic [127:0] rk_n, rnd_out, mixed, shifted;
  logic [15:0][7:0] sb, sr;
  logic [31:0] kw_t, kn0, kn1, kn2, kn3;
  logic [7:0]  rcon_q;
  logic [3:0]  rnd_q;
  logic        run_q, kbsy_q, dvld_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254 by square-and-multiply) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Next round key from the current one.
  always_comb begin
    kw_t = {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])}
           ^ {rcon_q, 24'h0};
    kn0  = rk_q[127:96] ^ kw_t;
    kn1  = rk_q[95:64]  ^ kn0;
    kn2  = rk_q[63:32]  ^ kn1;
    kn3  = rk_q[31:0]   ^ kn2;
    rk_n = {kn0, kn1, kn2, kn3};
  end

  // One full round: SubBytes, ShiftRows, MixColumns (skipped in round 10), AddRoundKey.
  always_comb begin
    sb      = '0;
    sr      = '0;
    mixed   = '0;
    shifted = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(st_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      shifted[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      mixed[127-32*c -: 32] = {
        xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3],
        sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3],
        sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3],
        xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3])};
    end
    rnd_out = ((rnd_q == 4'd10) ? shifted : mixed) ^ rk_n;
  end

  // Key capture, round sequencing and result register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      key_q <= '0; rk_q <= '0; st_q <= '0; dout_q <= '0;
      rcon_q <= '0; rnd_q <= '0; run_q <= 1'b0; kbsy_q <= 1'b0; dvld_q <= 1'b0;
    end else if (EN) begin
      dvld_q <= 1'b0;
      kbsy_q <= 1'b0;
      if (Krdy && !run_q) begin
        key_q  <= Key;
        kbsy_q <= 1'b1;
      end
      if (run_q) begin
        st_q   <= rnd_out;
        rk_q   <= rk_n;
        rcon_q <= xt(rcon_q);
        rnd_q  <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          run_q  <= 1'b0;
          dvld_q <= 1'b1;
          dout_q <= rnd_out;
        end
      end else if (Drdy) begin
        st_q   <= Din ^ key_q;
        rk_q   <= key_q;
        rcon_q <= 8'h01;
        rnd_q  <= 4'd1;
        run_q  <= 1'b1;
      end
    end
  end

  assign BSY  = run_q | kbsy_q;
  assign Dvld = dvld_q;
  assign Dout = dout_q;
endmodule

module aes_mode_ctrl #(
  parameter int DEPTH = 4,
  parameter int CTR_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] key,
  input  logic         key_load,
  input  logic [127:0] iv,
  input  logic [1:0]   mode,
  input  logic         start,
  input  logic [127:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
`ifdef AES_CTR_MODE_EN
  localparam logic [1:0] MODE_CTR = 2'b10;
`endif

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (CTR_W < 1 || CTR_W > 127) begin : g_bad_ctr_w
    $error("CTR_W must be in 1..127");
  end

  typedef enum logic [2:0] {S_IDLE, S_KEYX, S_READY, S_FEED, S_WAIT, S_PUSH} state_e;

  state_e       state_q;
  logic         key_ok_q, run_q, err_q, krdy_q, drdy_q;
  logic [1:0]   mode_q;
  logic [127:0] key_reg_q, core_din_q, chain_q, out_blk_q;
`ifdef AES_CTR_MODE_EN
  logic [127:0] ctr_q, din_hold_q;
`endif

  logic [127:0] in_mem  [DEPTH];
  logic [127:0] out_mem [DEPTH];
  logic [AW:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d, out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [AW:0]  in_cnt, out_cnt;
  logic         in_push, in_pop, out_push, out_pop, in_empty, mode_ok;
  logic [127:0] in_head, feed_blk, push_blk;
  logic [127:0] core_dout;
  logic         core_bsy, core_dvld, rst_n;

  assign rst_n = ~RST;

  AES_ENC u_core (
    .CLK  (CLK),
    .RSTn (rst_n),
    .EN   (1'b1),
    .Krdy (krdy_q),
    .Drdy (drdy_q),
    .Key  (key_reg_q),
    .Din  (core_din_q),
    .Dout (core_dout),
    .BSY  (core_bsy),
    .Dvld (core_dvld)
  );

  // FIFO occupancy, handshakes and next pointers.
  always_comb begin
    in_cnt     = in_wr_q - in_rd_q;
    out_cnt    = out_wr_q - out_rd_q;
    in_empty   = (in_cnt == '0);
    din_ready  = !RST && (in_cnt != FULL_CNT);
    dout_valid = (out_cnt != '0);
    in_push    = din_valid && din_ready;
    in_pop     = (state_q == S_FEED);
    out_push   = (state_q == S_PUSH);
    out_pop    = dout_valid && dout_ready;
    in_wr_d    = in_wr_q  + {{AW{1'b0}}, in_push};
    in_rd_d    = in_rd_q  + {{AW{1'b0}}, in_pop};
    out_wr_d   = out_wr_q + {{AW{1'b0}}, out_push};
    out_rd_d   = out_rd_q + {{AW{1'b0}}, out_pop};
    in_head    = in_mem[in_rd_q[AW-1:0]];
    dout       = dout_valid ? out_mem[out_rd_q[AW-1:0]] : '0;
    busy       = !(state_q == S_IDLE || state_q == S_READY) || core_bsy;
    err        = err_q;
  end

  // Mode legality and per-mode core input / output block selection.
  always_comb begin
    mode_ok  = (mode == MODE_ECB) || (mode == MODE_CBC);
    feed_blk = in_head;
    push_blk = core_dout;
    if (mode_q == MODE_CBC) feed_blk = in_head ^ chain_q;
`ifdef AES_CTR_MODE_EN
    if (mode == MODE_CTR) mode_ok = 1'b1;
    if (mode_q == MODE_CTR) begin
      feed_blk = ctr_q;
      push_blk = core_dout ^ din_hold_q;
    end
`endif
  end

  // FIFO pointers; RST flushes both FIFOs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_wr_q <= '0; in_rd_q <= '0; out_wr_q <= '0; out_rd_q <= '0;
    end else begin
      in_wr_q <= in_wr_d; in_rd_q <= in_rd_d; out_wr_q <= out_wr_d; out_rd_q <= out_rd_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge CLK) begin
    if (in_push)  in_mem[in_wr_q[AW-1:0]]   <= din;
    if (out_push) out_mem[out_wr_q[AW-1:0]] <= out_blk_q;
  end

  // Control FSM; Krdy/Drdy are registered one-cycle pulses issued on state entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE; key_ok_q <= 1'b0; run_q <= 1'b0; err_q <= 1'b0;
      krdy_q <= 1'b0; drdy_q <= 1'b0; mode_q <= '0;
      key_reg_q <= '0; core_din_q <= '0; chain_q <= '0; out_blk_q <= '0;
`ifdef AES_CTR_MODE_EN
      ctr_q <= '0; din_hold_q <= '0;
`endif
    end else begin
      krdy_q <= 1'b0;
      drdy_q <= 1'b0;
      case (state_q)
        S_IDLE, S_READY: begin
          if (key_load) begin
            key_reg_q <= key;
            krdy_q    <= 1'b1;
            key_ok_q  <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= S_KEYX;
          end else if (start) begin
            if (!key_ok_q || !mode_ok) begin
              err_q <= 1'b1;
            end else begin
              mode_q  <= mode;
              chain_q <= iv;
`ifdef AES_CTR_MODE_EN
              ctr_q   <= iv;
`endif
              run_q   <= 1'b1;
              state_q <= S_READY;
            end
          end else if (state_q == S_READY && run_q && !in_empty && out_cnt != FULL_CNT) begin
            core_din_q <= feed_blk;
            drdy_q     <= 1'b1;
            state_q    <= S_FEED;
          end
        end
        S_KEYX: begin
          if (key_load || start) err_q <= 1'b1;
          // The first KEYX cycle is the Krdy pulse itself; core BSY is seen a cycle later.
          if (!krdy_q && !core_bsy) begin
            key_ok_q <= 1'b1;
            run_q    <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_FEED: begin
          if (key_load || start) err_q <= 1'b1;
`ifdef AES_CTR_MODE_EN
          din_hold_q <= in_head;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (key_load || start) err_q <= 1'b1;
          if (core_dvld) begin
            out_blk_q <= push_blk;
            state_q   <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (key_load || start) err_q <= 1'b1;
          if (mode_q == MODE_CBC) chain_q <= out_blk_q;
`ifdef AES_CTR_MODE_EN
          if (mode_q == MODE_CTR)
            ctr_q <= {ctr_q[127:CTR_W], ctr_q[CTR_W-1:0] + CTR_W'(1)};
`endif
          state_q <= S_READY;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Scoreboard bench for aes_mode_ctrl: expected blocks come from a standalone
// AES-128 reference (log/antilog S-box) plus the mode chaining rules.
module tb_aes_mode_ctrl;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [127:0] key = '0;
  logic         key_load = 1'b0;
  logic [127:0] iv = '0;
  logic [1:0]   mode = '0;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         busy;
  logic         err;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 CLK = ~CLK;

  aes_mode_ctrl #(.DEPTH(4), .CTR_W(32)) dut (
    .CLK(CLK), .RST(RST), .key(key), .key_load(key_load), .iv(iv), .mode(mode),
    .start(start), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .err(err));

  int checks = 0;
  int errors = 0;
  int pops = 0;
  bit hold_out = 1'b0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  logic [127:0] m_key, m_chain, m_ctr;
  logic [1:0]   m_mode;

  function automatic logic [7:0] xt8(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] e[256];
    int lg[256];
    logic [7:0] x, inv;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      e[i] = x;
      lg[x] = i;
      x = xt8(x) ^ x;
    end
    sbox_t[0] = 8'h63;
    for (int a = 1; a < 256; a++) begin
      inv = e[(255 - lg[a]) % 255];
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w[44];
    logic [7:0]  s[16], t[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tw;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]} ^ {rc, 24'h0};
        rc = xt8(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox_t[s[4*(((j/4)+(j%4))%4)+(j%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rd < 10) begin
          s[4*c]   = xt8(a0) ^ (xt8(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt8(a1) ^ (xt8(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt8(a2) ^ (xt8(a3) ^ a3);
          s[4*c+3] = (xt8(a0) ^ a0) ^ a1 ^ a2 ^ xt8(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Expected output for one accepted block, from the mode rules.
  task automatic model_push(input logic [127:0] b, input bit use_k, input logic [127:0] kexp);
    logic [127:0] r;
    case (m_mode)
      2'b01: begin r = aes_ref(m_key, b ^ m_chain); m_chain = r; end
      2'b10: begin r = aes_ref(m_key, m_ctr) ^ b; m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1}; end
      default: r = aes_ref(m_key, b);
    endcase
    exp_q.push_back(use_k ? kexp : r);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic try_send(input logic [127:0] b, input bit use_k, input logic [127:0] kexp,
                          input int bound, output bit ok);
    din = b;
    din_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (din_ready) begin
        model_push(b, use_k, kexp);
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic send(input logic [127:0] b, input bit use_k, input logic [127:0] kexp);
    bit ok;
    try_send(b, use_k, kexp, 300, ok);
    chk("din_accept", {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    chk("idle_wait", {127'd0, ok}, 128'd1);
  endtask

  task automatic do_key(input logic [127:0] k);
    key = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    m_key = k;
    wait_idle();
  endtask

  task automatic do_start(input logic [127:0] v, input logic [1:0] md);
    iv = v;
    mode = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_mode = md;
    m_chain = v;
    m_ctr = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_left", 128'(exp_q.size()), 128'd0);
    repeat (3) tick();
  endtask

  task automatic chk_err(input string name, input logic expv);
    @(negedge CLK);
    chk(name, {127'd0, err}, {127'd0, expv});
    tick();
  endtask

  // Output-side backpressure driver.
  always @(posedge CLK) begin
    #1;
    dout_ready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor: compare every block the DUT hands over.
  always @(negedge CLK) begin
    if (!RST && dout_valid && dout_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", dout);
      end else begin
        chk("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc, p0;
    logic [127:0] v;
    build_sbox();
    m_key = '0; m_chain = '0; m_ctr = '0; m_mode = '0;

    // Reset state
    tick(); tick();
    @(negedge CLK);
    chk("rst_din_ready", {127'd0, din_ready}, 128'd0);
    chk("rst_dout_valid", {127'd0, dout_valid}, 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_din_ready", {127'd0, din_ready}, 128'd1);
    tick();

    // Error paths
    do_start('0, 2'b00);
    chk_err("err_start_nokey", 1'b1);
    do_key(K);
    chk_err("err_clr_by_key", 1'b0);
    do_start('0, 2'b11);
    chk_err("err_mode11", 1'b1);
    do_key(K);
    chk_err("err_clr2", 1'b0);

    // ECB known vector plus random blocks
    do_start('0, 2'b00);
    send(PT, 1'b1, CT);
    drain();
    chk_err("ecb_err", 1'b0);
    for (int n = 0; n < 10; n++) send(rnd128(), 1'b0, '0);
    drain();

    // CBC known chain plus random chain with random IV
    do_start('0, 2'b01);
    send(PT, 1'b1, CT);
    send(PT ^ CT, 1'b1, CT);
    drain();
    do_start(rnd128(), 2'b01);
    for (int n = 0; n < 8; n++) send(rnd128(), 1'b0, '0);
    drain();

`ifdef AES_CTR_MODE_EN
    do_start(PT, 2'b10);
    send('0, 1'b1, CT);
    drain();
    v = {rnd128() >> 32, 32'hffffffff};
    do_start(v, 2'b10);
    send('0, 1'b1, aes_ref(K, v));
    send('0, 1'b1, aes_ref(K, {v[127:32], 32'h00000000}));
    drain();
    do_start(rnd128(), 2'b10);
    for (int n = 0; n < 6; n++) send(rnd128(), 1'b0, '0);
    drain();
    chk_err("ctr_err", 1'b0);
`else
    do_start('0, 2'b10);
    chk_err("err_mode10_disabled", 1'b1);
    do_key(K);
    chk_err("err_clr3", 1'b0);
`endif

    // Backpressure: 4 in output FIFO + 4 in input FIFO, the 9th is refused
    do_start('0, 2'b00);
    hold_out = 1'b1;
    acc = 0;
    for (int n = 0; n < 9; n++) begin
      try_send(rnd128(), 1'b0, '0, 200, ok);
      if (ok) acc++;
    end
    @(negedge CLK);
    chk("bp_accepted", 128'(acc), 128'd8);
    chk("bp_din_ready", {127'd0, din_ready}, 128'd0);
    chk("bp_dout_valid", {127'd0, dout_valid}, 128'd1);
    tick();
    p0 = pops;
    hold_out = 1'b0;
    drain();
    chk("bp_pops", 128'(pops - p0), 128'd8);

    // Reset while a block is in WAIT
    do_start('0, 2'b00);
    send(rnd128(), 1'b0, '0);
    repeat (4) tick();
    @(negedge CLK);
    chk("wait_busy", {127'd0, busy}, 128'd1);
    tick();
    RST = 1'b1;
    exp_q.delete();
    tick();
    @(negedge CLK);
    chk("mid_rst_dout_valid", {127'd0, dout_valid}, 128'd0);
    chk("mid_rst_din_ready", {127'd0, din_ready}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    tick();
    RST = 1'b0;
    repeat (20) tick();
    @(negedge CLK);
    chk("aborted_no_output", {127'd0, dout_valid}, 128'd0);
    tick();
    do_start('0, 2'b00);
    chk_err("rst_cleared_key_ok", 1'b1);
    do_key(K);
    do_start('0, 2'b00);
    send(PT, 1'b1, CT);
    drain();
    chk_err("final_err", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
